// File: rtl/startup_sequencer.sv
// startup_sequencer: behavioural model of the FPGA configuration-startup primitive
module startup_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int GSR_CYCLES  = 8,
  parameter int STAGGER     = 4,
  parameter int PROG_USR    = 0,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gsr_req,
  input  logic              prog_req,
  input  logic              pack,
  output logic              gsr,
  output logic              eos,
  output logic              preq,
  output logic              reconfig,
  output logic [NUM_CH-1:0] user_rst
);
  localparam int LAST = GSR_CYCLES + STAGGER * NUM_CH;
  localparam int TOP  = (LAST + 1 > ACK_TIMEOUT) ? LAST + 1 : ACK_TIMEOUT;
  localparam int CW   = $clog2(TOP + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t G  = cnt_t'(GSR_CYCLES);
  localparam cnt_t L  = cnt_t'(LAST);
  localparam cnt_t T  = cnt_t'(TOP);
  localparam cnt_t TO = cnt_t'(ACK_TIMEOUT);
  typedef enum logic [1:0] {ST_GSR, ST_STAGGER, ST_RUN, ST_PREQ} state_t;
  state_t state, state_n;
  cnt_t cnt, cnt_n, c;
  logic seq, gsr_n, eos_n, preq_n, reconfig_n;
  logic [NUM_CH-1:0] user_rst_n;
  // cnt is the index of the startup cycle produced by the coming edge; c=0 restarts it
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    c = cnt;
    seq = 1'b0;
    gsr_n = 1'b0;
    eos_n = 1'b0;
    preq_n = 1'b0;
    reconfig_n = 1'b0;
    user_rst_n = '0;
    case (state)
      ST_GSR, ST_STAGGER: begin
        seq = 1'b1;
        c = gsr_req ? '0 : cnt;
      end
      ST_RUN: begin
        if (prog_req && PROG_USR != 0) begin
          state_n = ST_PREQ;
          cnt_n = cnt_t'(1);
          preq_n = 1'b1;
          eos_n = 1'b1;
        end else begin
          seq = prog_req || gsr_req;
          c = '0;
          reconfig_n = prog_req;
          eos_n = 1'b1;
        end
      end
      default: begin
        if (pack || (ACK_TIMEOUT != 0 && cnt == TO)) begin
          seq = 1'b1;
          c = '0;
          reconfig_n = 1'b1;
        end else begin
          preq_n = 1'b1;
          eos_n = 1'b1;
          cnt_n = (ACK_TIMEOUT != 0 && cnt != T) ? cnt + cnt_t'(1) : cnt;
        end
      end
    endcase
    if (seq) begin
      cnt_n = (c == T) ? c : c + cnt_t'(1);
      gsr_n = c < G;
      state_n = (c > L) ? ST_RUN : (c >= G) ? ST_STAGGER : ST_GSR;
      eos_n = c > L;
      for (int i = 0; i < NUM_CH; i++) user_rst_n[i] = c < cnt_t'(GSR_CYCLES + STAGGER * (i + 1));
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_GSR;
      cnt <= '0;
      gsr <= 1'b1;
      eos <= 1'b0;
      preq <= 1'b0;
      reconfig <= 1'b0;
      user_rst <= '1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gsr <= gsr_n;
      eos <= eos_n;
      preq <= preq_n;
      reconfig <= reconfig_n;
      user_rst <= user_rst_n;
    end
  end
endmodule

// File: tb/tb_startup_sequencer.sv
// tb_startup_sequencer: scoreboard bench for immediate (u0) and handshaked (u1) reprogramming
module tb_startup_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic gsr_req0 = 1'b0, prog_req0 = 1'b0, pack0 = 1'b0;
  logic gsr_req1 = 1'b0, prog_req1 = 1'b0, pack1 = 1'b0;
  logic gsr0, eos0, preq0, reconfig0, gsr1, eos1, preq1, reconfig1;
  logic [3:0] ur0, ur1;
  logic [7:0] q0[$], q1[$];
  int compared = 0, mismatched = 0, cyc_n = 0;
  localparam logic [7:0] RST = 8'h8F, RUN = 8'h40, PQ = 8'h60, RC = 8'h10;
  startup_sequencer #(.PROG_USR(0)) u0 (
    .clk(clk), .reset(reset), .gsr_req(gsr_req0), .prog_req(prog_req0), .pack(pack0),
    .gsr(gsr0), .eos(eos0), .preq(preq0), .user_rst(ur0), .reconfig(reconfig0)
  );
  startup_sequencer #(.PROG_USR(1), .ACK_TIMEOUT(16)) u1 (
    .clk(clk), .reset(reset), .gsr_req(gsr_req1), .prog_req(prog_req1), .pack(pack1),
    .gsr(gsr1), .eos(eos1), .preq(preq1), .user_rst(ur1), .reconfig(reconfig1)
  );
  always #5 clk = ~clk;
  // {gsr, eos, preq, reconfig, user_rst[3:0]} at startup cycle t with default timing
  function automatic logic [7:0] seqv(input int t);
    return {t < 8, t >= 25, 2'b00, t < 24, t < 20, t < 16, t < 12};
  endfunction
  task automatic step(input logic [7:0] e0, input logic [7:0] e1);
    @(posedge clk);
    q0.push_back(e0);
    q1.push_back(e1);
    #1;
  endtask
  task automatic run_seq(input int a, input int b, input bit d0, input bit d1);
    for (int t = a; t <= b; t++) step(d0 ? seqv(t) : RUN, d1 ? seqv(t) : RUN);
  endtask
  task automatic check(input int dut, input logic [7:0] exp, input logic [7:0] got);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL dut%0d cycle %0d {gsr,eos,preq,reconfig,user_rst}: got %b expected %b", dut, cyc_n, got, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc_n++;
    if (q0.size() > 0) check(0, q0.pop_front(), {gsr0, eos0, preq0, reconfig0, ur0});
    if (q1.size() > 0) check(1, q1.pop_front(), {gsr1, eos1, preq1, reconfig1, ur1});
  end
  initial begin
    repeat (2) step(RST, RST);
    reset = 1'b0;
    run_seq(0, 29, 1, 1);
    gsr_req0 = 1'b1; gsr_req1 = 1'b1;
    step(seqv(0), seqv(0));
    gsr_req0 = 1'b0; gsr_req1 = 1'b0;
    run_seq(1, 13, 1, 1);
    gsr_req0 = 1'b1; gsr_req1 = 1'b1;
    step(seqv(0), seqv(0));
    gsr_req0 = 1'b0; gsr_req1 = 1'b0;
    run_seq(1, 29, 1, 1);
    prog_req0 = 1'b1;
    step(RC | seqv(0), RUN);
    run_seq(1, 25, 1, 0);
    step(RC | seqv(0), RUN);
    prog_req0 = 1'b0;
    run_seq(1, 29, 1, 0);
    gsr_req0 = 1'b1; prog_req0 = 1'b1; pack1 = 1'b1;
    step(RC | seqv(0), RUN);
    gsr_req0 = 1'b0; prog_req0 = 1'b0; pack1 = 1'b0;
    run_seq(1, 29, 1, 0);
    prog_req1 = 1'b1;
    step(RUN, PQ);
    prog_req1 = 1'b0;
    for (int j = 1; j < 5; j++) begin
      gsr_req1 = (j == 2);
      step(RUN, PQ);
    end
    gsr_req1 = 1'b0; pack1 = 1'b1;
    step(RUN, RC | seqv(0));
    pack1 = 1'b0;
    run_seq(1, 29, 0, 1);
    prog_req1 = 1'b1;
    step(RUN, PQ);
    prog_req1 = 1'b0;
    repeat (15) step(RUN, PQ);
    step(RUN, RC | seqv(0));
    run_seq(1, 29, 0, 1);
    prog_req1 = 1'b1;
    step(RUN, PQ);
    prog_req1 = 1'b0;
    repeat (3) step(RUN, PQ);
    reset = 1'b1;
    step(RST, RST);
    reset = 1'b0;
    run_seq(0, 29, 1, 1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
